// File: rtl/seq_index_driver.sv
// seq_index_driver: generates the seqidx stepping sequence for the LED
// pattern sequencer and checks the returned leds pattern against the
// expected rotating pattern for the current index.
//
// Control is a two-state FSM (IDLE/RUN). The registered busy output mirrors
// state==RUN and serves as the observable state of the FSM.
//
// Handshake: there is none. leds_in is treated as a purely combinational
// function of the registered seqidx (zero sequencer latency), so every
// non-reset cycle is a valid comparison cycle.
module seq_index_driver #(
  parameter int IDX_W = 5,
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  input  logic             oneshot,
  input  logic             dir,
  input  logic             step,
  input  logic             clr_err,
  input  logic [7:0]       leds_in,
  output logic [IDX_W-1:0] seqidx,
  output logic             busy,
  output logic             wrap,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nx;
  logic             adv;
  logic [IDX_W-1:0] idx_step;
  logic             idx_wraps;
  logic [3:0]       nib;
  logic [7:0]       exp_leds;
  logic             mismatch;

  // Candidate next index and whether taking it crosses the wrap boundary.
  always_comb begin
    idx_step  = dir ? (seqidx - IDX_ONE) : (seqidx + IDX_ONE);
    idx_wraps = dir ? (seqidx == '0) : (seqidx == '1);
  end

  // Expected sequencer pattern for the current index and the mismatch flag.
  always_comb begin
    nib      = 4'b1000 >> seqidx[1:0];
    exp_leds = {nib, nib};
    mismatch = (leds_in != exp_leds);
  end

  // Next-state, prescaler and advance decision.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    adv      = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          // Entry edge only arms the prescaler; no advance here.
          state_nx = RUN;
          cnt_nx   = '0;
        end else if (step) begin
          adv    = 1'b1;
          cnt_nx = '0;
        end
      end
      RUN: begin
        if (!run) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt >= div) begin
          // >= rather than == so lowering div below cnt still advances
          // on the very next cycle.
          adv    = 1'b1;
          cnt_nx = '0;
          if (oneshot && idx_wraps) begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + DIV_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // FSM state, prescaler, index and wrap pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      seqidx <= '0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      busy  <= (state_nx == RUN);
      wrap  <= adv && idx_wraps;
      if (adv) begin
        seqidx <= idx_step;
      end
    end
  end

  // Sticky mismatch flag and saturating mismatch counter; clear has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (clr_err) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (mismatch) begin
      err <= 1'b1;
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_seq_index_driver.sv
// Testbench for seq_index_driver: directed stimulus with hand-computed
// expectations queued per cycle and checked by an independent monitor.
module tb_seq_index_driver;

  localparam int IDX_W = 5;
  localparam int DIV_W = 16;
  localparam int CNT_W = 8;
  // Queue entry: {due_cycle[31:0], field[2:0], value[7:0]}
  localparam int W = 43;

  localparam int F_IDX  = 0;
  localparam int F_BUSY = 1;
  localparam int F_WRAP = 2;
  localparam int F_ERR  = 3;
  localparam int F_ECNT = 4;

  logic             clk;
  logic             rst;
  logic [DIV_W-1:0] div;
  logic             run;
  logic             oneshot;
  logic             dir;
  logic             step;
  logic             clr_err;
  logic [7:0]       leds_in;
  logic [IDX_W-1:0] seqidx;
  logic             busy;
  logic             wrap;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  logic             bad;
  logic [3:0]       seq_nib;
  int               cyc;
  int               total;
  int               nbad;
  logic [W-1:0]     exp_q[$];

  seq_index_driver #(
    .IDX_W(IDX_W),
    .DIV_W(DIV_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .div    (div),
    .run    (run),
    .oneshot(oneshot),
    .dir    (dir),
    .step   (step),
    .clr_err(clr_err),
    .leds_in(leds_in),
    .seqidx (seqidx),
    .busy   (busy),
    .wrap   (wrap),
    .err    (err),
    .err_cnt(err_cnt)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal pattern sequencer; bad forces an all-zero pattern.
  always_comb begin
    seq_nib = 4'b1000 >> seqidx[1:0];
    leds_in = bad ? 8'h00 : {seq_nib, seq_nib};
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue an expectation for the outputs visible in the current cycle.
  task automatic expect_v(input int f, input int v);
    logic [31:0] due;
    logic [2:0]  ff;
    logic [7:0]  vv;
    due = cyc;
    ff  = f[2:0];
    vv  = v[7:0];
    exp_q.push_back({due, ff, vv});
  endtask

  task automatic expect_all(input int idx, input int b, input int w,
                            input int e, input int ec);
    expect_v(F_IDX, idx);
    expect_v(F_BUSY, b);
    expect_v(F_WRAP, w);
    expect_v(F_ERR, e);
    expect_v(F_ECNT, ec);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  function automatic logic [7:0] field_val(input logic [2:0] f);
    case (f)
      3'd0:    field_val = {3'b000, seqidx};
      3'd1:    field_val = {7'd0, busy};
      3'd2:    field_val = {7'd0, wrap};
      3'd3:    field_val = {7'd0, err};
      default: field_val = err_cnt;
    endcase
  endfunction

  function automatic string field_name(input logic [2:0] f);
    case (f)
      3'd0:    field_name = "seqidx";
      3'd1:    field_name = "busy";
      3'd2:    field_name = "wrap";
      3'd3:    field_name = "err";
      default: field_name = "err_cnt";
    endcase
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [7:0]   act;
    while (exp_q.size() != 0 && int'(exp_q[0][42:11]) <= cyc) begin
      e   = exp_q.pop_front();
      act = field_val(e[10:8]);
      total = total + 1;
      if (int'(e[42:11]) != cyc) begin
        nbad = nbad + 1;
        $display("FAIL %s: check for cycle %0d missed (now %0d)",
                 field_name(e[10:8]), e[42:11], cyc);
      end else if (act != e[7:0]) begin
        nbad = nbad + 1;
        $display("FAIL %s @cycle %0d: got %0d expected %0d",
                 field_name(e[10:8]), cyc, act, e[7:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0; total = 0; nbad = 0;
    rst = 1'b1; div = '0; run = 1'b0; oneshot = 1'b0; dir = 1'b0;
    step = 1'b0; clr_err = 1'b0; bad = 1'b0;

    // Reset state
    tick(2);
    expect_all(0, 0, 0, 0, 0);
    rst = 1'b0;

    // Idle single steps, dir up: 0 -> 1 -> 2 -> 3
    pulse_step(); expect_v(F_IDX, 1);
    pulse_step(); expect_v(F_IDX, 2);
    pulse_step(); expect_all(3, 0, 0, 0, 0);

    // step and run together: only RUN entry, no advance
    div = 16'd5; step = 1'b1; run = 1'b1;
    tick(1); expect_v(F_IDX, 3); expect_v(F_BUSY, 1);
    // step held during RUN is ignored; advance period is div+1 = 6
    tick(3); expect_v(F_IDX, 3);
    step = 1'b0;
    tick(2); expect_v(F_IDX, 3);
    tick(1); expect_v(F_IDX, 4);
    run = 1'b0;
    tick(1); expect_v(F_BUSY, 0); expect_v(F_IDX, 4);

    // Reset overrides run; then div=3 stepping
    rst = 1'b1; run = 1'b1; div = 16'd3; dir = 1'b0;
    tick(1); expect_all(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(1); expect_v(F_BUSY, 1); expect_v(F_IDX, 0);
    tick(3); expect_v(F_IDX, 0);
    tick(1); expect_v(F_IDX, 1); expect_v(F_WRAP, 0);
    tick(3); expect_v(F_IDX, 1);
    tick(1); expect_v(F_IDX, 2);
    tick(4); expect_v(F_IDX, 3);
    run = 1'b0;
    tick(1); expect_v(F_BUSY, 0); expect_v(F_IDX, 3);

    // Idle steps down through the 0 -> 31 wrap to 30
    dir = 1'b1;
    pulse_step(); expect_v(F_IDX, 2);
    pulse_step(); expect_v(F_IDX, 1);
    pulse_step(); expect_v(F_IDX, 0); expect_v(F_WRAP, 0);
    pulse_step(); expect_v(F_IDX, 31); expect_v(F_WRAP, 1);
    pulse_step(); expect_v(F_IDX, 30); expect_v(F_WRAP, 0);

    // div=0 run up from 30: 30, 31, 0 (wrap), 1
    dir = 1'b0; div = 16'd0; run = 1'b1;
    tick(1); expect_v(F_BUSY, 1); expect_v(F_IDX, 30);
    tick(1); expect_v(F_IDX, 31); expect_v(F_WRAP, 0);
    tick(1); expect_v(F_IDX, 0); expect_v(F_WRAP, 1);
    tick(1); expect_v(F_IDX, 1); expect_v(F_WRAP, 0);
    run = 1'b0;
    tick(1); expect_v(F_BUSY, 0); expect_v(F_IDX, 1);

    // One-shot down sweep from 2: 1, 0, 31 then stop
    pulse_step(); expect_v(F_IDX, 2);
    dir = 1'b1; oneshot = 1'b1; run = 1'b1;
    tick(1); expect_v(F_BUSY, 1); expect_v(F_IDX, 2);
    tick(1); expect_v(F_IDX, 1);
    tick(1); expect_v(F_IDX, 0); expect_v(F_WRAP, 0);
    tick(1); expect_v(F_IDX, 31); expect_v(F_WRAP, 1); expect_v(F_BUSY, 0);
    run = 1'b0;
    tick(1); expect_v(F_IDX, 31); expect_v(F_WRAP, 0); expect_v(F_BUSY, 0);
    tick(3); expect_v(F_IDX, 31); expect_v(F_BUSY, 0);
    // run held high re-enters RUN
    run = 1'b1;
    tick(1); expect_v(F_BUSY, 1); expect_v(F_IDX, 31);
    tick(1); expect_v(F_IDX, 30);
    run = 1'b0; oneshot = 1'b0;
    tick(1); expect_v(F_BUSY, 0); expect_v(F_IDX, 30);

    // 64-index sweep with ideal sequencer: no errors
    dir = 1'b0; run = 1'b1;
    tick(65); expect_all(30, 1, 0, 0, 0);
    run = 1'b0;
    tick(1); expect_v(F_BUSY, 0); expect_v(F_ECNT, 0);

    // Five forced mismatch cycles
    bad = 1'b1;
    tick(5);
    bad = 1'b0;
    expect_v(F_ERR, 1); expect_v(F_ECNT, 5);
    tick(1); expect_v(F_ERR, 1); expect_v(F_ECNT, 5);
    clr_err = 1'b1;
    tick(1); expect_v(F_ERR, 0); expect_v(F_ECNT, 0);

    // Clear wins over a coincident mismatch, then saturation
    bad = 1'b1;
    tick(1); expect_v(F_ERR, 0); expect_v(F_ECNT, 0);
    clr_err = 1'b0;
    tick(1); expect_v(F_ERR, 1); expect_v(F_ECNT, 1);
    tick(253); expect_v(F_ECNT, 254);
    tick(1); expect_v(F_ECNT, 255);
    tick(45); expect_v(F_ECNT, 255);
    bad = 1'b0;
    tick(1); expect_v(F_ECNT, 255); expect_v(F_ERR, 1);
    clr_err = 1'b1;
    tick(1); expect_v(F_ERR, 0); expect_v(F_ECNT, 0);
    clr_err = 1'b0;

    // Reset mid-RUN at seqidx=17 with a nonzero prescaler
    div = 16'd0; run = 1'b1;
    tick(1); expect_v(F_IDX, 30);
    tick(19); expect_v(F_IDX, 17);
    div = 16'd7; bad = 1'b1;
    tick(2); expect_v(F_IDX, 17); expect_v(F_ERR, 1); expect_v(F_ECNT, 2);
    bad = 1'b0; rst = 1'b1;
    tick(1); expect_all(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(1); expect_v(F_BUSY, 1); expect_v(F_IDX, 0);
    tick(7); expect_v(F_IDX, 0);
    tick(1); expect_v(F_IDX, 1); expect_v(F_ERR, 0);
    run = 1'b0;
    tick(1); expect_v(F_BUSY, 0);

    // Drain and report
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total = total + 1;
      nbad = nbad + 1;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
